// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Purpose  : Shared opcode constants, instruction class, sequencer state and
//            decoded instruction-kind types for the bus-datapath sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_COPY   = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_ALU_LO = 4'b0010;
    localparam logic [3:0] OP_ALU_HI = 4'b1011;

    typedef enum logic [1:0] {
        CLS_REG  = 2'b00,
        CLS_ADDI = 2'b01,
        CLS_ILL  = 2'b10,
        CLS_SUBI = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        T1    = 2'd1,
        T2    = 2'd2,
        T3    = 2'd3
    } st_e;

    typedef enum logic [2:0] {
        K_LOAD = 3'd0,
        K_COPY = 3'd1,
        K_ALU  = 3'd2,
        K_ADDI = 3'd3,
        K_SUBI = 3'd4,
        K_ILL  = 3'd5
    } kind_e;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/proc_ir_decode.sv
`default_nettype none
// ============================================================================
// Module   : proc_ir_decode
// Purpose  : Combinational instruction decoder: register fields, opcode,
//            instruction kind and the (possibly negated) immediate value.
// Revision : 1.0 - initial release
// ============================================================================
module proc_ir_decode
    import proc_pkg::*;
#(
    parameter  int REG_AW = 2,
    parameter  int DATA_W = 10,
    localparam int IR_W   = 2*REG_AW+6
) (
    input  logic [IR_W-1:0]   ir,
    output logic [REG_AW-1:0] rx,
    output logic [REG_AW-1:0] ry,
    output logic [3:0]        op,
    output kind_e             kind,
    output logic [DATA_W-1:0] imm_val
);

    localparam int IMM_W = REG_AW+4;

    cls_e              w_cls;
    logic [IMM_W-1:0]  w_field;
    logic [DATA_W-1:0] w_zext;

    assign rx      = ir[IR_W-1 -: REG_AW];
    assign ry      = ir[IR_W-1-REG_AW -: REG_AW];
    assign op      = ir[5:2];
    assign w_cls   = cls_e'(ir[1:0]);
    // The immediate reuses the Ry and op bits as one contiguous field.
    assign w_field = ir[IMM_W+1:2];
    assign w_zext  = DATA_W'(w_field);

    // Classify the instruction; class 10 and reserved register ops are illegal.
    always_comb begin
        kind = K_ILL;
        case (w_cls)
            CLS_REG: begin
                if (op == OP_LOAD)
                    kind = K_LOAD;
                else if (op == OP_COPY)
                    kind = K_COPY;
                else if (op >= OP_ALU_LO && op <= OP_ALU_HI)
                    kind = K_ALU;
                else
                    kind = K_ILL;
            end
            CLS_ADDI: kind = K_ADDI;
            CLS_SUBI: kind = K_SUBI;
            default:  kind = K_ILL;
        endcase
    end

    // SUBI feeds the adder with the negated immediate, wrapping at bus width.
    assign imm_val = (kind == K_SUBI) ? (-w_zext) : w_zext;

endmodule : proc_ir_decode
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : proc_sequencer
// Purpose  : Multi-cycle instruction sequencer for the shared-bus datapath,
//            with fetch handshake, LOAD data stall and illegal-op reporting.
// Revision : 1.0 - initial release
// ============================================================================
module proc_sequencer
    import proc_pkg::*;
#(
    parameter  int REG_AW = 2,
    parameter  int DATA_W = 10,
    localparam int IR_W   = 2*REG_AW+6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              data_valid,
    output logic [DATA_W-1:0] imm,
    output logic              imm_en,
    output logic [REG_AW-1:0] rin,
    output logic [REG_AW-1:0] rout,
    output logic              enw,
    output logic              enr,
    output logic              ain,
    output logic              gin,
    output logic              gout,
    output logic [3:0]        alu_op,
    output logic              ext,
    output logic              busy,
    output logic              instr_done,
    output logic              illegal
);

    st_e               r_state;
    logic [IR_W-1:0]   r_ir;
    logic [REG_AW-1:0] w_rx;
    logic [REG_AW-1:0] w_ry;
    logic [3:0]        w_op;
    kind_e             w_kind;
    logic [DATA_W-1:0] w_imm;

    proc_ir_decode #(
        .REG_AW (REG_AW),
        .DATA_W (DATA_W)
    ) u_decode (
        .ir      (r_ir),
        .rx      (w_rx),
        .ry      (w_ry),
        .op      (w_op),
        .kind    (w_kind),
        .imm_val (w_imm)
    );

    // Timestep state machine and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ir    <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instr_in;
                        r_state <= T1;
                    end
                end
                T1: begin
                    case (w_kind)
                        K_LOAD:                r_state <= data_valid ? FETCH : T1;
                        K_ALU, K_ADDI, K_SUBI: r_state <= T2;
                        default:               r_state <= FETCH;
                    endcase
                end
                T2:      r_state <= T3;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Control outputs decoded from timestep and instruction; one bus driver max.
    always_comb begin
        instr_ready = (r_state == FETCH);
        busy        = (r_state != FETCH);
        imm         = '0;
        imm_en      = 1'b0;
        rin         = '0;
        rout        = '0;
        enw         = 1'b0;
        enr         = 1'b0;
        ain         = 1'b0;
        gin         = 1'b0;
        gout        = 1'b0;
        alu_op      = 4'b0000;
        ext         = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            T1: begin
                case (w_kind)
                    K_LOAD: begin
                        ext = 1'b1;
                        rin = w_rx;
                        if (data_valid) begin
                            enw        = 1'b1;
                            instr_done = 1'b1;
                        end
                    end
                    K_COPY: begin
                        enr        = 1'b1;
                        rout       = w_ry;
                        enw        = 1'b1;
                        rin        = w_rx;
                        instr_done = 1'b1;
                    end
                    K_ALU, K_ADDI, K_SUBI: begin
                        enr  = 1'b1;
                        rout = w_rx;
                        ain  = 1'b1;
                    end
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                gin = 1'b1;
                if (w_kind == K_ALU) begin
                    enr    = 1'b1;
                    rout   = w_ry;
                    alu_op = w_op;
                end else begin
                    imm_en = 1'b1;
                    imm    = w_imm;
                    alu_op = OP_ADD;
                end
            end
            T3: begin
                gout       = 1'b1;
                enw        = 1'b1;
                rin        = w_rx;
                alu_op     = (w_kind == K_ALU) ? w_op : OP_ADD;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : proc_sequencer
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_sequencer
// Purpose  : Directed vector bench for proc_sequencer (REG_AW=2, DATA_W=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_sequencer;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       imm_en;
        logic [9:0] imm;
        logic [1:0] rin;
        logic [1:0] rout;
        logic       enw;
        logic       enr;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu_op;
        logic       ext;
        logic       done;
        logic       ill;
    } out_t;

    typedef struct {
        string      name;
        logic [9:0] instr;
        int         n;
        out_t [3:0] exp;
    } vec_t;

    localparam int E_ENR  = 1;
    localparam int E_ENW  = 2;
    localparam int E_AIN  = 4;
    localparam int E_GIN  = 8;
    localparam int E_GOUT = 16;
    localparam int E_EXT  = 32;
    localparam int E_IMM  = 64;
    localparam int E_DONE = 128;
    localparam int E_ILL  = 256;

    logic       clk;
    logic       rst_n;
    logic [9:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic       data_valid;
    logic [9:0] imm;
    logic       imm_en;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw;
    logic       enr;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] alu_op;
    logic       ext;
    logic       busy;
    logic       instr_done;
    logic       illegal;

    int tests;
    int fails;
    vec_t vecs[11];

    proc_sequencer #(
        .REG_AW (2),
        .DATA_W (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .data_valid  (data_valid),
        .imm         (imm),
        .imm_en      (imm_en),
        .rin         (rin),
        .rout        (rout),
        .enw         (enw),
        .enr         (enr),
        .ain         (ain),
        .gin         (gin),
        .gout        (gout),
        .alu_op      (alu_op),
        .ext         (ext),
        .busy        (busy),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input int m, input int ri, input int ro, input int alu, input int im);
        out_t e;
        e        = '0;
        e.busy   = 1'b1;
        e.enr    = (m & E_ENR)  != 0;
        e.enw    = (m & E_ENW)  != 0;
        e.ain    = (m & E_AIN)  != 0;
        e.gin    = (m & E_GIN)  != 0;
        e.gout   = (m & E_GOUT) != 0;
        e.ext    = (m & E_EXT)  != 0;
        e.imm_en = (m & E_IMM)  != 0;
        e.done   = (m & E_DONE) != 0;
        e.ill    = (m & E_ILL)  != 0;
        e.rin    = ri[1:0];
        e.rout   = ro[1:0];
        e.alu_op = alu[3:0];
        e.imm    = im[9:0];
        return e;
    endfunction

    function automatic out_t fetch_o();
        out_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic out_t cur();
        out_t a;
        a.ready  = instr_ready;
        a.busy   = busy;
        a.imm_en = imm_en;
        a.imm    = imm;
        a.rin    = rin;
        a.rout   = rout;
        a.enw    = enw;
        a.enr    = enr;
        a.ain    = ain;
        a.gin    = gin;
        a.gout   = gout;
        a.alu_op = alu_op;
        a.ext    = ext;
        a.done   = instr_done;
        a.ill    = illegal;
        return a;
    endfunction

    task automatic chk(input string name, input out_t exp);
        out_t act;
        act   = cur();
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Present one instruction in FETCH and walk its timesteps.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        instr_in    = v.instr;
        instr_valid = 1'b1;
        data_valid  = 1'b1;
        #1 chk({v.name, " fetch"}, fetch_o());
        for (int s = 0; s < v.n; s++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr_in    = 10'($urandom);
            #1 chk($sformatf("%s step%0d", v.name, s + 1), v.exp[s]);
        end
        @(negedge clk);
        #1 chk({v.name, " return"}, fetch_o());
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        instr_in    = '0;
        instr_valid = 1'b0;
        data_valid  = 1'b0;

        vecs[0]  = '{"COPY", 10'h204, 1, '{default: '0}};
        vecs[0].exp[0]  = mk(E_ENR | E_ENW | E_DONE, 2, 0, 0, 0);
        vecs[1]  = '{"LOAD_nostall", 10'h280, 1, '{default: '0}};
        vecs[1].exp[0]  = mk(E_EXT | E_ENW | E_DONE, 2, 0, 0, 0);
        vecs[2]  = '{"ADD", 10'h188, 3, '{default: '0}};
        vecs[2].exp[0]  = mk(E_ENR | E_AIN, 0, 1, 0, 0);
        vecs[2].exp[1]  = mk(E_ENR | E_GIN, 0, 2, 2, 0);
        vecs[2].exp[2]  = mk(E_GOUT | E_ENW | E_DONE, 1, 0, 2, 0);
        vecs[3]  = '{"ADDI", 10'h215, 3, '{default: '0}};
        vecs[3].exp[0]  = mk(E_ENR | E_AIN, 0, 2, 0, 0);
        vecs[3].exp[1]  = mk(E_IMM | E_GIN, 0, 0, 2, 10'h005);
        vecs[3].exp[2]  = mk(E_GOUT | E_ENW | E_DONE, 2, 0, 2, 0);
        vecs[4]  = '{"SUBI", 10'h217, 3, '{default: '0}};
        vecs[4].exp[0]  = mk(E_ENR | E_AIN, 0, 2, 0, 0);
        vecs[4].exp[1]  = mk(E_IMM | E_GIN, 0, 0, 2, 10'h3FB);
        vecs[4].exp[2]  = mk(E_GOUT | E_ENW | E_DONE, 2, 0, 2, 0);
        vecs[5]  = '{"SUBI_zero", 10'h103, 3, '{default: '0}};
        vecs[5].exp[0]  = mk(E_ENR | E_AIN, 0, 1, 0, 0);
        vecs[5].exp[1]  = mk(E_IMM | E_GIN, 0, 0, 2, 0);
        vecs[5].exp[2]  = mk(E_GOUT | E_ENW | E_DONE, 1, 0, 2, 0);
        vecs[6]  = '{"ILL_cls10", 10'h002, 1, '{default: '0}};
        vecs[6].exp[0]  = mk(E_ILL | E_DONE, 0, 0, 0, 0);
        vecs[7]  = '{"ILL_op1100", 10'h030, 1, '{default: '0}};
        vecs[7].exp[0]  = mk(E_ILL | E_DONE, 0, 0, 0, 0);
        vecs[8]  = '{"ALU_op1011", 10'h32C, 3, '{default: '0}};
        vecs[8].exp[0]  = mk(E_ENR | E_AIN, 0, 3, 0, 0);
        vecs[8].exp[1]  = mk(E_ENR | E_GIN, 0, 0, 11, 0);
        vecs[8].exp[2]  = mk(E_GOUT | E_ENW | E_DONE, 3, 0, 11, 0);
        vecs[9]  = '{"ILL_op1111", 10'h03C, 1, '{default: '0}};
        vecs[9].exp[0]  = mk(E_ILL | E_DONE, 0, 0, 0, 0);
        vecs[10] = '{"ILL_cls10_full", 10'h3FE, 1, '{default: '0}};
        vecs[10].exp[0] = mk(E_ILL | E_DONE, 0, 0, 0, 0);

        // Reset state, both during and after reset.
        repeat (2) @(posedge clk);
        #1 chk("reset_active", fetch_o());
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_released", fetch_o());

        foreach (vecs[i]) run_vec(vecs[i]);

        // LOAD R3 with three stall cycles before data arrives.
        @(negedge clk);
        instr_in    = 10'h300;
        instr_valid = 1'b1;
        data_valid  = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1 chk($sformatf("LOAD stall%0d", s + 1), mk(E_EXT, 3, 0, 0, 0));
            @(negedge clk);
        end
        data_valid = 1'b1;
        #1 chk("LOAD complete", mk(E_EXT | E_ENW | E_DONE, 3, 0, 0, 0));
        @(negedge clk);
        data_valid = 1'b0;
        #1 chk("LOAD return", fetch_o());

        // ADD followed by a COPY held valid throughout: accepted only in FETCH.
        instr_in    = 10'h188;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_in    = 10'h204;
        #1 chk("hold T1", mk(E_ENR | E_AIN, 0, 1, 0, 0));
        @(negedge clk);
        #1 chk("hold T2", mk(E_ENR | E_GIN, 0, 2, 2, 0));
        @(negedge clk);
        #1 chk("hold T3", mk(E_GOUT | E_ENW | E_DONE, 1, 0, 2, 0));
        @(negedge clk);
        #1 chk("hold fetch", fetch_o());
        @(negedge clk);
        instr_valid = 1'b0;
        #1 chk("hold COPY T1", mk(E_ENR | E_ENW | E_DONE, 2, 0, 0, 0));
        @(negedge clk);
        #1 chk("hold COPY return", fetch_o());

        // Asynchronous reset in the middle of an ALU instruction.
        instr_in    = 10'h188;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1 chk("rst pre T2", mk(E_ENR | E_GIN, 0, 2, 2, 0));
        rst_n = 1'b0;
        #1 chk("rst in T2", fetch_o());
        @(posedge clk);
        #1 chk_bit("rst enw held low", enw, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst released", fetch_o());
        @(posedge clk);
        #1 chk_bit("rst no late write", enw, 1'b0);
        @(negedge clk);
        #1 chk("rst idle fetch", fetch_o());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_proc_sequencer
`default_nettype wire
